// File: rtl/round_controller.sv
// Baccarat round sequencer: deals four cards, applies the third-card rules, settles, then holds the result.
// Moore FSM; load/enable outputs decode the current state, win lights are registered on the SETTLE exit edge.
module round_controller #(
   parameter int unsigned RESULT_HOLD = 4
) (
   input  logic       slow_clock,
   input  logic       resetb,
   input  logic       bet_confirm,
   input  logic [3:0] pcard3_out,
   input  logic [3:0] pscore_out,
   input  logic [3:0] dscore_out,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       betenabled,
   output logic       updatebalanceenable,
   output logic       player_win_light,
   output logic       dealer_win_light,
   output logic       round_done
);

   typedef enum logic [3:0] {
      S_BET     = 4'd0,
      S_DEAL_P1 = 4'd1,
      S_DEAL_D1 = 4'd2,
      S_DEAL_P2 = 4'd3,
      S_DEAL_D2 = 4'd4,
      S_EVAL    = 4'd5,
      S_DEAL_P3 = 4'd6,
      S_EVAL_D3 = 4'd7,
      S_DEAL_D3 = 4'd8,
      S_SETTLE  = 4'd9,
      S_RESULT  = 4'd10
   } state_t;

   localparam logic [3:0] HOLD_INIT = 4'(RESULT_HOLD - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_hold;
   logic       r_pwin;
   logic       r_dwin;
   logic [3:0] w_v;
   logic       w_dealer_draws;

   // Face cards and tens count as zero for the dealer's third-card rule.
   assign w_v = (pcard3_out >= 4'd10) ? 4'd0 : pcard3_out;

   always_comb begin
      w_dealer_draws = 1'b0;
      case (dscore_out)
         4'd0, 4'd1, 4'd2: w_dealer_draws = 1'b1;
         4'd3:             w_dealer_draws = (w_v != 4'd8);
         4'd4:             w_dealer_draws = (w_v >= 4'd2) && (w_v <= 4'd7);
         4'd5:             w_dealer_draws = (w_v >= 4'd4) && (w_v <= 4'd7);
         4'd6:             w_dealer_draws = (w_v >= 4'd6) && (w_v <= 4'd7);
         default:          w_dealer_draws = 1'b0;
      endcase
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         r_state <= S_BET;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         r_hold <= 4'd0;
         r_pwin <= 1'b0;
         r_dwin <= 1'b0;
      end else if (r_state == S_SETTLE) begin
         r_hold <= HOLD_INIT;
         r_pwin <= (pscore_out >= dscore_out);
         r_dwin <= (dscore_out >= pscore_out);
      end else if (r_state == S_RESULT) begin
         if (r_hold == 4'd0) begin
            r_pwin <= 1'b0;
            r_dwin <= 1'b0;
         end else begin
            r_hold <= r_hold - 4'd1;
         end
      end
   end

   always_comb begin
      w_next              = r_state;
      load_pcard1         = 1'b0;
      load_pcard2         = 1'b0;
      load_pcard3         = 1'b0;
      load_dcard1         = 1'b0;
      load_dcard2         = 1'b0;
      load_dcard3         = 1'b0;
      betenabled          = 1'b0;
      updatebalanceenable = 1'b0;
      round_done          = 1'b0;
      case (r_state)
         S_BET: begin
            betenabled = 1'b1;
            if (bet_confirm) w_next = S_DEAL_P1;
         end
         S_DEAL_P1: begin
            load_pcard1 = 1'b1;
            w_next      = S_DEAL_D1;
         end
         S_DEAL_D1: begin
            load_dcard1 = 1'b1;
            w_next      = S_DEAL_P2;
         end
         S_DEAL_P2: begin
            load_pcard2 = 1'b1;
            w_next      = S_DEAL_D2;
         end
         S_DEAL_D2: begin
            load_dcard2 = 1'b1;
            w_next      = S_EVAL;
         end
         S_EVAL: begin
            if ((pscore_out >= 4'd8) || (dscore_out >= 4'd8)) w_next = S_SETTLE;
            else if (pscore_out <= 4'd5)                      w_next = S_DEAL_P3;
            else if (dscore_out <= 4'd5)                      w_next = S_DEAL_D3;
            else                                              w_next = S_SETTLE;
         end
         S_DEAL_P3: begin
            load_pcard3 = 1'b1;
            w_next      = S_EVAL_D3;
         end
         S_EVAL_D3: begin
            w_next = w_dealer_draws ? S_DEAL_D3 : S_SETTLE;
         end
         S_DEAL_D3: begin
            load_dcard3 = 1'b1;
            w_next      = S_SETTLE;
         end
         S_SETTLE: begin
            updatebalanceenable = 1'b1;
            w_next              = S_RESULT;
         end
         S_RESULT: begin
            round_done = 1'b1;
            if (r_hold == 4'd0) w_next = S_BET;
         end
         default: begin
            w_next = S_BET;
         end
      endcase
   end

   assign player_win_light = r_pwin;
   assign dealer_win_light = r_dwin;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: table of whole rounds plus reset and back-to-back sequences.
module tb_round_controller;

   logic       slow_clock;
   logic       resetb;
   logic       bet_confirm;
   logic [3:0] pcard3_out;
   logic [3:0] pscore_out;
   logic [3:0] dscore_out;
   logic       load_pcard1, load_pcard2, load_pcard3;
   logic       load_dcard1, load_dcard2, load_dcard3;
   logic       betenabled, updatebalanceenable;
   logic       player_win_light, dealer_win_light, round_done;

   int n_cmp  = 0;
   int n_fail = 0;

   round_controller #(.RESULT_HOLD(4)) dut (
      .slow_clock          (slow_clock),
      .resetb              (resetb),
      .bet_confirm         (bet_confirm),
      .pcard3_out          (pcard3_out),
      .pscore_out          (pscore_out),
      .dscore_out          (dscore_out),
      .load_pcard1         (load_pcard1),
      .load_pcard2         (load_pcard2),
      .load_pcard3         (load_pcard3),
      .load_dcard1         (load_dcard1),
      .load_dcard2         (load_dcard2),
      .load_dcard3         (load_dcard3),
      .betenabled          (betenabled),
      .updatebalanceenable (updatebalanceenable),
      .player_win_light    (player_win_light),
      .dealer_win_light    (dealer_win_light),
      .round_done          (round_done)
   );

   initial begin
      slow_clock = 1'b0;
      forever #5 slow_clock = ~slow_clock;
   end

   // ps0/ds0: scores after four cards; ps1/ds1: scores after the respective third card.
   typedef struct {
      logic [3:0] ps0;
      logic [3:0] ds0;
      logic [3:0] pc3;
      logic [3:0] ps1;
      logic [3:0] ds1;
      int         exp_p3;
      int         exp_d3;
      int         exp_pl;
      int         exp_dl;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_round(input vec_t v, input bit pulse, input string tag);
      int  c_p1 = 0, c_p2 = 0, c_p3 = 0, c_d1 = 0, c_d2 = 0, c_d3 = 0;
      int  c_upd = 0, c_rd = 0;
      bit  done = 0, multi = 0;
      pscore_out = v.ps0;
      dscore_out = v.ds0;
      pcard3_out = v.pc3;
      check({tag, "_bet_idle"}, int'(betenabled), 1);
      bet_confirm = 1'b1;
      @(negedge slow_clock);
      bet_confirm = 1'b0;
      check({tag, "_first_p1"}, int'(load_pcard1), 1);
      for (int k = 0; k < 40 && !done; k++) begin
         if (betenabled) begin
            done = 1;
            check({tag, "_pl_clear"}, int'(player_win_light), 0);
            check({tag, "_dl_clear"}, int'(dealer_win_light), 0);
         end else begin
            c_p1 += int'(load_pcard1);
            c_p2 += int'(load_pcard2);
            c_p3 += int'(load_pcard3);
            c_d1 += int'(load_dcard1);
            c_d2 += int'(load_dcard2);
            c_d3 += int'(load_dcard3);
            c_upd += int'(updatebalanceenable);
            if ((int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3) + int'(load_dcard1)
                 + int'(load_dcard2) + int'(load_dcard3)) > 1) multi = 1;
            if (load_pcard3) pscore_out = v.ps1;
            if (load_dcard3) dscore_out = v.ds1;
            if (round_done) begin
               if (c_rd == 0) begin
                  check({tag, "_pl"}, int'(player_win_light), v.exp_pl);
                  check({tag, "_dl"}, int'(dealer_win_light), v.exp_dl);
               end
               c_rd++;
            end
            bet_confirm = pulse && (k % 2 == 1) && !round_done;
            @(negedge slow_clock);
         end
      end
      bet_confirm = 1'b0;
      check({tag, "_timeout"}, int'(done), 1);
      check({tag, "_p1"}, c_p1, 1);
      check({tag, "_d1"}, c_d1, 1);
      check({tag, "_p2"}, c_p2, 1);
      check({tag, "_d2"}, c_d2, 1);
      check({tag, "_p3"}, c_p3, v.exp_p3);
      check({tag, "_d3"}, c_d3, v.exp_d3);
      check({tag, "_upd"}, c_upd, 1);
      check({tag, "_rdone"}, c_rd, 4);
      check({tag, "_multi"}, int'(multi), 0);
   endtask

   initial begin
      //          ps0    ds0    pc3     ps1    ds1   p3 d3 pl dl
      vecs[0]  = '{4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 0, 0, 1, 0};
      vecs[1]  = '{4'd6, 4'd4, 4'd0,  4'd6, 4'd7, 0, 1, 0, 1};
      vecs[2]  = '{4'd2, 4'd6, 4'd7,  4'd9, 4'd8, 1, 1, 1, 0};
      vecs[3]  = '{4'd2, 4'd6, 4'd12, 4'd2, 4'd6, 1, 0, 0, 1};
      vecs[4]  = '{4'd3, 4'd3, 4'd8,  4'd1, 4'd3, 1, 0, 0, 1};
      vecs[5]  = '{4'd5, 4'd5, 4'd10, 4'd5, 4'd5, 1, 0, 1, 1};
      vecs[6]  = '{4'd7, 4'd9, 4'd0,  4'd7, 4'd9, 0, 0, 0, 1};
      vecs[7]  = '{4'd7, 4'd7, 4'd0,  4'd7, 4'd7, 0, 0, 1, 1};
      vecs[8]  = '{4'd1, 4'd7, 4'd5,  4'd6, 4'd7, 1, 0, 0, 1};
      vecs[9]  = '{4'd4, 4'd4, 4'd1,  4'd5, 4'd4, 1, 0, 1, 0};
      vecs[10] = '{4'd0, 4'd5, 4'd4,  4'd4, 4'd9, 1, 1, 0, 1};
      vecs[11] = '{4'd0, 4'd2, 4'd13, 4'd0, 4'd0, 1, 1, 1, 1};

      resetb      = 1'b0;
      bet_confirm = 1'b0;
      pcard3_out  = 4'd0;
      pscore_out  = 4'd0;
      dscore_out  = 4'd0;
      #3;
      check("rst_bet", int'(betenabled), 1);
      check("rst_loads", int'(load_pcard1 | load_pcard2 | load_pcard3 | load_dcard1 | load_dcard2 | load_dcard3), 0);
      check("rst_upd", int'(updatebalanceenable), 0);
      check("rst_lights", int'(player_win_light | dealer_win_light), 0);
      check("rst_rdone", int'(round_done), 0);
      @(negedge slow_clock);
      resetb = 1'b1;
      @(negedge slow_clock);
      check("idle_stays_bet", int'(betenabled), 1);

      for (int i = 0; i < 12; i++) begin
         run_round(vecs[i], i[0], $sformatf("v%0d", i));
      end

      // Reset while dealing the player's second card.
      bet_confirm = 1'b1;
      @(negedge slow_clock);
      bet_confirm = 1'b0;
      @(negedge slow_clock);
      @(negedge slow_clock);
      check("pre_rst_p2", int'(load_pcard2), 1);
      resetb = 1'b0;
      #1;
      check("midrst_loads", int'(load_pcard1 | load_pcard2 | load_pcard3 | load_dcard1 | load_dcard2 | load_dcard3), 0);
      check("midrst_bet", int'(betenabled), 1);
      check("midrst_upd", int'(updatebalanceenable), 0);
      @(negedge slow_clock);
      resetb = 1'b1;
      @(negedge slow_clock);
      check("postrst_bet", int'(betenabled), 1);
      run_round(vecs[0], 1'b0, "post_rst");

      // bet_confirm held high: 3 natural rounds of 11 cycles each.
      begin
         int c_bet = 0, c_upd = 0, c_rd = 0, c_p3 = 0;
         pscore_out  = 4'd8;
         dscore_out  = 4'd3;
         bet_confirm = 1'b1;
         for (int k = 0; k < 33; k++) begin
            c_bet += int'(betenabled);
            c_upd += int'(updatebalanceenable);
            c_rd  += int'(round_done);
            c_p3  += int'(load_pcard3) + int'(load_dcard3);
            @(negedge slow_clock);
         end
         bet_confirm = 1'b0;
         check("b2b_bet", c_bet, 3);
         check("b2b_upd", c_upd, 3);
         check("b2b_rdone", c_rd, 12);
         check("b2b_third", c_p3, 0);
         check("b2b_end_bet", int'(betenabled), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
